// File: rtl/fp_normalize.sv
// rtl/fp_normalize.sv - FP32 post-add normalizer: carry right-shift, iterative left-shift, zero/ovf/unf flags
module fp_normalize (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [22:0] out_frac,
    output logic        out_zero,
    output logic        out_ovf,
    output logic        out_unf
);

    typedef enum logic [1:0] {IDLE, CHECK, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic        sign_q;
    logic [7:0]  exp_q;
    logic [24:0] mant_q;

    logic        work_load;
    logic [7:0]  exp_nxt;
    logic [24:0] mant_nxt;
    logic        res_load;
    logic [7:0]  res_exp;
    logic [22:0] res_frac;
    logic        res_zero, res_ovf, res_unf;
    logic [7:0]  exp_inc, exp_dec;

    assign exp_inc   = exp_q + 8'd1;
    assign exp_dec   = exp_q - 8'd1;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        work_load = 1'b0;
        exp_nxt   = exp_q;
        mant_nxt  = mant_q;
        res_load  = 1'b0;
        res_exp   = exp_q;
        res_frac  = mant_q[22:0];
        res_zero  = 1'b0;
        res_ovf   = 1'b0;
        res_unf   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_load = 1'b1;
                    exp_nxt   = in_exp;
                    mant_nxt  = in_mant;
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (mant_q == 25'd0) begin
                    res_load  = 1'b1;
                    res_exp   = 8'd0;
                    res_frac  = 23'd0;
                    res_zero  = 1'b1;
                    state_nxt = DONE;
                end else if (mant_q[24]) begin
                    // Adder carry: one right shift, the dropped LSB is simply truncated
                    res_load  = 1'b1;
                    state_nxt = DONE;
                    if (exp_inc == 8'hFF) begin
                        res_exp  = 8'hFF;
                        res_frac = 23'd0;
                        res_ovf  = 1'b1;
                    end else begin
                        res_exp  = exp_inc;
                        res_frac = mant_q[23:1];
                    end
                end else if (mant_q[23]) begin
                    res_load  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (exp_q <= 8'd1) begin
                    res_load  = 1'b1;
                    res_exp   = 8'd0;
                    res_frac  = 23'd0;
                    res_zero  = 1'b1;
                    res_unf   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    work_load = 1'b1;
                    mant_nxt  = {mant_q[23:0], 1'b0};
                    exp_nxt   = exp_dec;
                    if (mant_q[22]) begin
                        res_load  = 1'b1;
                        res_exp   = exp_dec;
                        res_frac  = {mant_q[21:0], 1'b0};
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Result registers are written only on entry to DONE so they hold through backpressure and after
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q   <= 1'b0;
            exp_q    <= 8'd0;
            mant_q   <= 25'd0;
            out_sign <= 1'b0;
            out_exp  <= 8'd0;
            out_frac <= 23'd0;
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
        end else begin
            if (in_ready && in_valid) sign_q <= in_sign;
            if (work_load) begin
                exp_q  <= exp_nxt;
                mant_q <= mant_nxt;
            end
            if (res_load) begin
                out_sign <= sign_q;
                out_exp  <= res_exp;
                out_frac <= res_frac;
                out_zero <= res_zero;
                out_ovf  <= res_ovf;
                out_unf  <= res_unf;
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize.sv
// tb/tb_fp_normalize.sv - directed self-checking bench for fp_normalize with a behavioural result model
module tb_fp_normalize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [24:0] in_mant = 25'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic        out_zero, out_ovf, out_unf;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        zero;
        logic        ovf;
        logic        unf;
        logic        flush;
        logic [7:0]  e;
        logic [22:0] f;
        logic [5:0]  k;
    } res_t;

    res_t x_res;
    logic x_sign;
    logic pending = 1'b0;

    fp_normalize dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
        .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    always #5 clk = ~clk;

    // Result from the arithmetic meaning: find the leading one, shift it to bit 23, see if the exponent survives
    function automatic res_t model(input logic [7:0] e, input logic [24:0] m);
        res_t        r;
        int          p, n, ei;
        logic [24:0] sh;
        r  = '0;
        ei = int'(e);
        if (m == 25'd0) begin
            r.zero = 1'b1;
        end else if (m >= 25'h1000000) begin
            if (ei + 1 == 255) begin
                r.ovf = 1'b1;
                r.e   = 8'hFF;
            end else begin
                r.e = 8'(ei + 1);
                sh  = m >> 1;
                r.f = sh[22:0];
            end
        end else if (m >= 25'h0800000) begin
            r.e = e;
            r.f = m[22:0];
        end else begin
            p = 0;
            for (int i = 0; i < 23; i++) if (m[i]) p = i;
            n = 23 - p;
            if (ei > n) begin
                r.e = 8'(ei - n);
                sh  = m << n;
                r.f = sh[22:0];
                r.k = 6'(n);
            end else begin
                r.zero  = 1'b1;
                r.unf   = 1'b1;
                r.flush = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic pin(input string name, input res_t r, input logic [2:0] flags,
                       input logic [7:0] e, input logic [22:0] f, input logic [5:0] k);
        check(name, {r.zero, r.ovf, r.unf, r.e, r.f, r.k}, {flags, e, f, k});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!pending) begin
                check("spurious_out_valid", 64'(out_valid), 64'd0);
            end else begin
                check("result", {out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf},
                      {x_sign, x_res.e, x_res.f, x_res.zero, x_res.ovf, x_res.unf});
                check("in_ready_in_done", 64'(in_ready), 64'd0);
            end
        end
    end

    task automatic run_case(input logic s, input logic [7:0] e, input logic [24:0] m, input int stall);
        res_t r;
        int   n;
        r = model(e, m);
        @(negedge clk);
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        x_sign   = s;
        x_res    = r;
        pending  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        if (!out_valid) begin
            check("out_valid_timeout", 64'(out_valid), 64'd1);
            pending = 1'b0;
            return;
        end
        if (!r.flush) check("latency", 64'(n), 64'(2 + int'(r.k)));
        for (int i = 0; i < stall; i++) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        pending = 1'b0;
        @(negedge clk);
        check("after_done_handshake", {out_valid, in_ready}, 2'b01);
        check("retained", {out_sign, out_exp, out_frac, out_zero}, {s, r.e, r.f, r.zero});
    endtask

    initial begin
        pin("pin_norm",  model(8'h80, 25'h0800000), 3'b000, 8'h80, 23'h0,      6'd0);
        pin("pin_carry", model(8'h7F, 25'h1000001), 3'b000, 8'h80, 23'h0,      6'd0);
        pin("pin_max",   model(8'h90, 25'h0000001), 3'b000, 8'h79, 23'h0,      6'd23);
        pin("pin_ovf",   model(8'hFE, 25'h1000000), 3'b010, 8'hFF, 23'h0,      6'd0);
        pin("pin_unf",   model(8'h02, 25'h0200000), 3'b101, 8'h00, 23'h0,      6'd0);
        pin("pin_zero",  model(8'h55, 25'h0000000), 3'b100, 8'h00, 23'h0,      6'd0);
        pin("pin_one",   model(8'h40, 25'h0400001), 3'b000, 8'h3F, 23'h000002, 6'd1);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {out_valid, in_ready, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf},
              {2'b01, 1'b0, 8'h0, 23'h0, 3'b000});

        run_case(1'b1, 8'h80, 25'h0800000, 0);
        run_case(1'b0, 8'h7F, 25'h1000001, 0);
        run_case(1'b0, 8'h90, 25'h0000001, 0);
        run_case(1'b1, 8'hFE, 25'h1000000, 2);
        run_case(1'b1, 8'h02, 25'h0200000, 0);
        run_case(1'b1, 8'h55, 25'h0000000, 5);
        run_case(1'b0, 8'h40, 25'h0400001, 0);
        run_case(1'b1, 8'h85, 25'h1FFFFFF, 1);
        run_case(1'b0, 8'h17, 25'h0000003, 0);
        run_case(1'b1, 8'h16, 25'h0000003, 0);
        run_case(1'b0, 8'h01, 25'h0400000, 0);

        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b1;
        in_exp   = 8'h90;
        in_mant  = 25'h0000001;
        pending  = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_mid_shift", {out_valid, in_ready, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf},
              {2'b01, 1'b0, 8'h0, 23'h0, 3'b000});
        repeat (30) @(negedge clk);
        check("no_output_after_reset", 64'(out_valid), 64'd0);

        run_case(1'b0, 8'h80, 25'h0C00000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_normalize.md
FP_NORMALIZE -- requirements
Module: fp_normalize

Interface
REQ-001 SHALL have a single clock domain: all state updates on the rising edge of clk, reset synchronous and active-low on rst_n.
REQ-002 SHALL have ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  upstream mantissa-adder result valid
in_ready  out  1  block can accept a result
in_sign  in  1  result sign
in_exp  in  8  biased exponent (FP32, bias 127)
in_mant  in  25  raw ripple-adder sum; bit24 = adder Cout, bit23 = hidden-bit position
out_valid  out  1  normalized result valid
out_ready  in  1  downstream accepts result
out_sign  out  1  sign
out_exp  out  8  normalized biased exponent
out_frac  out  23  fraction, hidden bit removed
out_zero  out  1  result is zero
out_ovf  out  1  exponent overflow, result is infinity
out_unf  out  1  exponent underflow, result flushed to zero

Function
REQ-003 SHALL implement FSM states IDLE, CHECK, SHIFT, DONE.
REQ-004 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both decoded from state.
REQ-005 IDLE: on in_valid=1, register sign/exp/mant and go to CHECK; otherwise stay in IDLE.
REQ-006 CHECK, priority order: mant==0 -> zero result (exp 0, frac 0, out_zero=1), DONE; mant[24]=1 -> mant>>=1 (LSB truncated), exp+=1, DONE, with out_ovf=1, exp=0xFF, frac=0 if the incremented exp equals 0xFF; mant[23]=1 -> DONE unchanged; else SHIFT.
REQ-007 SHIFT, once per cycle: if exp<=1, flush (exp 0, frac 0, out_zero=1, out_unf=1) and go to DONE; else mant<<=1, exp-=1, go to DONE if pre-shift mant[22]=1, otherwise stay in SHIFT.
REQ-008 Latency: with input handshake at edge T, out_valid SHALL rise at T+2+k, where k = number of left shifts (0..23).
REQ-009 No rounding: right shift drops bit0, and left shift fills zeros.
REQ-010 sign SHALL pass through unchanged in every case, including zero, overflow and underflow.
REQ-011 DONE: all out_* SHALL hold stable while out_valid=1 and out_ready=0; on out_ready=1 go to IDLE (in_ready=1 the following cycle, with no same-cycle accept).
REQ-012 out_zero, out_ovf and out_unf SHALL be mutually exclusive except that out_unf=1 always implies out_zero=1.
REQ-013 Data outputs SHALL retain the last result after leaving DONE until the next result is written.

Reset
REQ-014 rst_n=0 at a rising edge SHALL force IDLE, out_valid=0, in_ready=1, and out_sign/out_exp/out_frac/out_zero/out_ovf/out_unf=0, from any state including mid-SHIFT or a stalled DONE.
REQ-015 A transaction interrupted by reset SHALL be discarded without producing output.

Verification
REQ-016 Already normalized: exp 0x80, mant 0x0800000, sign 1 -> out_valid at T+2, sign 1, exp 0x80, frac 0x000000, all flags 0.
REQ-017 Carry: exp 0x7F, mant 0x1000001 -> T+2, exp 0x80, frac 0x000000 (bit0 truncated).
REQ-018 Max left shift: exp 0x90, mant 0x0000001 -> out_valid at T+25, exp 0x79, frac 0x000000.
REQ-019 Overflow and underflow: exp 0xFE, mant 0x1000000 -> exp 0xFF, frac 0, out_ovf=1; exp 0x02, mant 0x0200000 -> out_zero=1, out_unf=1, exp 0, frac 0.
REQ-020 Backpressure and zero: mant 0, exp 0x55 -> out_zero=1, exp 0; with out_ready=0 for 5 cycles, outputs stay stable and in_ready stays 0.
REQ-021 Reset mid-SHIFT: rst_n=0 for 1 cycle during the REQ-018 case -> next cycle IDLE, out_valid=0, in_ready=1, and no result is ever emitted.
